mux2x1_rr_arbiter: RTL and testbench
====================================

MUX2X1_RR_ARBITER -- requirements
Module: mux2x1_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of each requester word and of the shared output.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have ports req0 and req1, input, 1 each, requester 0/1 has a word pending.
REQ-005 SHALL have ports a0 and a1, input, WIDTH each, requester 0/1 data word, held stable while its req is high.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 each, requester 0/1 currently owns the mux; decoded directly from state.
REQ-007 SHALL have ports ack0 and ack1, output, 1 each, single-cycle pulse: the requester's word is taken this cycle.
REQ-008 SHALL have port s, output, 1, the current mux select: 0 selects a0, 1 selects a1.
REQ-009 SHALL have port y, output, WIDTH, the registered shared output word.
REQ-010 SHALL have ports y_valid (output, 1) and y_ready (input, 1) forming the downstream valid/ready handshake.

Function
REQ-011 SHALL implement a state machine with states IDLE, GNT0 and GNT1; gnt0=(state==GNT0), gnt1=(state==GNT1), s=(state==GNT1); s holds its last value in IDLE.
REQ-012 SHALL keep a round-robin pointer naming the preferred requester; it favours the requester not most recently acked.
REQ-013 SHALL move IDLE to GNTx on any request: sole requester wins; if both request, the pointer's requester wins.
REQ-014 SHALL define load = !y_valid || y_ready; ackx = gntx && reqx && load.
REQ-015 SHALL, on ackx, register y <= ax and y_valid <= 1 at the next edge, and set the pointer to the other requester.
REQ-016 SHALL, after ackx, move to GNT(other) if the other requester is requesting, else stay in GNTx if reqx is still high, else go to IDLE.
REQ-017 SHALL, in GNTx with reqx low, release to GNT(other) if the other requester is requesting, else go to IDLE; no ack is issued.
REQ-018 SHALL hold GNTx with no ack while load is 0 (downstream stall); y and y_valid stay unchanged.
REQ-019 SHALL clear y_valid when y_ready=1 and no ack occurs in that cycle.
REQ-020 SHALL give a latency of one cycle from req in IDLE to gnt, and one cycle from ack to y_valid.
REQ-021 SHALL sustain one word per cycle with both requesters active and y_ready=1, alternating 0,1,0,1.

Reset
REQ-022 SHALL, on rst_n low and regardless of clk, force state=IDLE, pointer=0, s=0, y=0 and y_valid=0; gnt and ack go low.
REQ-023 SHALL discard any in-flight grant or output word on mid-operation reset; arbitration restarts from IDLE after rst_n rises.

Configuration
REQ-024 SHALL, with MUX2X1_ARB_LOCK_EN defined, add inputs lock0 and lock1 (1 bit each); when lockx=1 at ackx, the FSM stays in GNTx and the pointer is not updated.
REQ-025 SHALL, without MUX2X1_ARB_LOCK_EN, omit lock0 and lock1 and behave exactly as if both were tied to 0.

Structure
REQ-026 SHALL take the state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) from the shared include file mux2x1_arb_defs.vh.
REQ-027 SHALL instantiate one sub-module, mux2x1_word, a WIDTH-parameterised combinational 2:1 mux driven by s that feeds the y register.

Verification
REQ-028 Reset: rst_n=0 asynchronously mid-cycle during GNT1 -> gnt1=0, y=0, y_valid=0 and s=0 immediately.
REQ-029 Single request: req0=1, a0=8'hA5, y_ready=1 from IDLE -> gnt0 at cycle +1, ack0 at +1, y=8'hA5 with y_valid=1 at +2.
REQ-030 Contention: req0=req1=1 continuously, a0=8'h11, a1=8'h22, y_ready=1 -> y alternates 11,22,11,22, one word per cycle, s toggles.
REQ-031 Stall: y_valid=1, y_ready=0 for 3 cycles while req1=1 -> no ack1 and y held; y_ready=1 -> ack1 in that same cycle.
REQ-032 Withdraw: in GNT0, req0 drops and req1=1 -> next state GNT1 with no ack0; if req1=0 instead -> IDLE.
REQ-033 Lock (MUX2X1_ARB_LOCK_EN): lock0=1, req0=req1=1 for 4 words -> four consecutive ack0 and no gnt1 until lock0=0.

Source files
------------

// File: rtl/mux2x1_rr_arbiter_pkg.sv
// rtl/mux2x1_rr_arbiter_pkg.sv - state type and arbitration helper for mux2x1_rr_arbiter
package mux2x1_rr_arbiter_pkg;
`include "mux2x1_arb_defs.vh"

  typedef enum logic [1:0] {
    IDLE = `MUX2X1_ARB_IDLE,
    GNT0 = `MUX2X1_ARB_GNT0,
    GNT1 = `MUX2X1_ARB_GNT1
  } state_t;

  // Sole requester wins; on contention the preferred requester (ptr) wins.
  function automatic state_t arb_pick(input logic req0, input logic req1, input logic ptr);
    if (req0 && req1) return ptr ? GNT1 : GNT0;
    else if (req0)    return GNT0;
    else if (req1)    return GNT1;
    else              return IDLE;
  endfunction
endpackage

// File: rtl/mux2x1_arb_defs.vh
// rtl/mux2x1_arb_defs.vh - shared state encodings for the 2:1 round-robin arbiter
`ifndef MUX2X1_ARB_DEFS_VH
`define MUX2X1_ARB_DEFS_VH
`define MUX2X1_ARB_IDLE 2'd0
`define MUX2X1_ARB_GNT0 2'd1
`define MUX2X1_ARB_GNT1 2'd2
`endif

// File: rtl/mux2x1_rr_arbiter_word.sv
// rtl/mux2x1_rr_arbiter_word.sv - combinational WIDTH-bit 2:1 word mux
module mux2x1_word #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] y
);
  assign y = s ? a1 : a0;
endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// rtl/mux2x1_rr_arbiter.sv - two-requester round-robin arbiter feeding a registered 2:1 mux
// Optional MUX2X1_ARB_LOCK_EN adds lock0/lock1 to hold a grant across acks.
module mux2x1_rr_arbiter
  import mux2x1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
`ifdef MUX2X1_ARB_LOCK_EN
  input  logic             lock0,
  input  logic             lock1,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

`ifndef MUX2X1_ARB_LOCK_EN
  logic lock0;
  logic lock1;
  assign lock0 = 1'b0;
  assign lock1 = 1'b0;
`endif

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             s_last;
  logic             load;
  logic [WIDTH-1:0] y_mux;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);
  assign s    = (state == GNT1) || ((state == IDLE) && s_last);
  assign load = !y_valid || y_ready;
  assign ack0 = gnt0 && req0 && load;
  assign ack1 = gnt1 && req1 && load;

  mux2x1_word #(.WIDTH(WIDTH)) u_word (
    .s  (s),
    .a0 (a0),
    .a1 (a1),
    .y  (y_mux)
  );

  // Leaving a grant (withdraw or unlocked ack) prefers the other requester.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = arb_pick(req0, req1, ptr);
      GNT0: if (!req0 || (ack0 && !lock0)) state_next = arb_pick(req0, req1, 1'b1);
      GNT1: if (!req1 || (ack1 && !lock1)) state_next = arb_pick(req0, req1, 1'b0);
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      s_last <= 1'b0;
    end else begin
      state  <= state_next;
      s_last <= s;
      if (ack0 && !lock0)      ptr <= 1'b1;
      else if (ack1 && !lock1) ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (ack0 || ack1) begin
      y       <= y_mux;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// tb/tb_mux2x1_rr_arbiter.sv - directed self-checking bench for mux2x1_rr_arbiter
module tb_mux2x1_rr_arbiter;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, a1;
  logic             gnt0, gnt1, ack0, ack1, s;
  logic [WIDTH-1:0] y;
  logic             y_valid, y_ready;
`ifdef MUX2X1_ARB_LOCK_EN
  logic             lock0, lock1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mux2x1_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .a1      (a1),
`ifdef MUX2X1_ARB_LOCK_EN
    .lock0   (lock0),
    .lock1   (lock1),
`endif
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .ack0    (ack0),
    .ack1    (ack1),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0; y_ready = 1'b0;
`ifdef MUX2X1_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    cyc(); cyc(); #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_s", s, 0);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    rst_n = 1'b1;

    // single request from IDLE
    cyc(); req0 = 1'b1; a0 = 8'hA5; y_ready = 1'b1; #1;
    check("single_idle_gnt0", gnt0, 0);
    check("single_idle_ack0", ack0, 0);
    cyc(); #1;
    check("single_gnt0", gnt0, 1);
    check("single_ack0", ack0, 1);
    check("single_s", s, 0);
    cyc(); #1;
    check("single_y", y, 8'hA5);
    check("single_y_valid", y_valid, 1);
    req0 = 1'b0; #1;
    check("single_drop_ack0", ack0, 0);
    cyc(); #1;
    check("single_idle_again", gnt0, 0);
    check("single_y_valid_clr", y_valid, 0);
    check("single_y_hold", y, 8'hA5);

    // contention: alternating words, pointer restarts at 0 after reset
    do_reset();
    req0 = 1'b1; req1 = 1'b1; a0 = 8'h11; a1 = 8'h22; y_ready = 1'b1;
    cyc(); #1;
    check("cont_first_gnt0", gnt0, 1);
    check("cont_first_ack0", ack0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check("cont_y", y, (k % 2 == 0) ? 8'h11 : 8'h22);
      check("cont_y_valid", y_valid, 1);
      check("cont_s", s, (k % 2 == 0) ? 1 : 0);
    end
    cyc(); #1;
    check("cont_gnt1_before_rst", gnt1, 1);

    // asynchronous reset mid-cycle while in GNT1
    rst_n = 1'b0; #1;
    check("arst_gnt1", gnt1, 0);
    check("arst_y", y, 0);
    check("arst_y_valid", y_valid, 0);
    check("arst_s", s, 0);
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    rst_n = 1'b1;

    // downstream stall with req1 pending
    req1 = 1'b1; a1 = 8'h5A; y_ready = 1'b1;
    cyc(); #1;
    check("stall_gnt1", gnt1, 1);
    check("stall_first_ack1", ack1, 1);
    cyc(); y_ready = 1'b0; a1 = 8'hC3; #1;
    check("stall_y_first", y, 8'h5A);
    check("stall_ack1_0", ack1, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      check("stall_ack1", ack1, 0);
      check("stall_y_hold", y, 8'h5A);
      check("stall_y_valid", y_valid, 1);
      check("stall_gnt1_hold", gnt1, 1);
    end
    cyc(); y_ready = 1'b1; #1;
    check("stall_release_ack1", ack1, 1);
    cyc(); #1;
    check("stall_y_new", y, 8'hC3);
    check("stall_y_valid_new", y_valid, 1);
    req1 = 1'b0;
    cyc(); #1;
    check("stall_idle_gnt1", gnt1, 0);
    check("stall_idle_y_valid", y_valid, 0);
    check("idle_s_hold", s, 1);

    // withdraw from GNT0 with req1 waiting, then with nobody waiting
    req0 = 1'b1;
    cyc(); #1;
    check("wd_gnt0", gnt0, 1);
    req0 = 1'b0; req1 = 1'b1; #1;
    check("wd_no_ack0", ack0, 0);
    cyc(); #1;
    check("wd_to_gnt1", gnt1, 1);
    check("wd_gnt0_low", gnt0, 0);
    check("wd_y_unchanged", y, 8'hC3);
    req1 = 1'b0;
    cyc(); #1;
    check("wd_idle", gnt1, 0);
    req0 = 1'b1;
    cyc(); #1;
    check("wd2_gnt0", gnt0, 1);
    req0 = 1'b0;
    cyc(); #1;
    check("wd2_idle_gnt0", gnt0, 0);
    check("wd2_idle_gnt1", gnt1, 0);
    check("wd2_y_valid", y_valid, 0);

`ifdef MUX2X1_ARB_LOCK_EN
    do_reset();
    lock0 = 1'b1; req0 = 1'b1; req1 = 1'b1; a0 = 8'h11; a1 = 8'h22; y_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check("lock_ack0", ack0, 1);
      check("lock_no_gnt1", gnt1, 0);
      if (k == 3) lock0 = 1'b0;
    end
    cyc(); #1;
    check("lock_release_gnt1", gnt1, 1);
    req0 = 1'b0; req1 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
